// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the instruction source and the immediate consumer
// around imm_gen_pipe: instruction in, decoded immediate out.
interface imm_gen_pipe_if #(
  parameter int XLEN = 64
);
  logic [31:0]     Instruction;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] imm_data;
  logic [2:0]      imm_fmt;
  logic            illegal;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output Instruction, in_valid, out_ready,
    input  in_ready, imm_data, imm_fmt, illegal, out_valid
  );

  modport slave (
    input  Instruction, in_valid, out_ready,
    output in_ready, imm_data, imm_fmt, illegal, out_valid
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV64I immediate generator: decodes I/S/B/U/J immediates into a small FIFO.
// Optional statistics counters enabled by defining IMMGEN_STATS_EN.
module imm_gen_pipe #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  imm_gen_pipe_if.slave    bus
`ifdef IMMGEN_STATS_EN
  ,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = XLEN + 4;

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // Entry layout {illegal, fmt, imm}; the reset value doubles as the idle head value.
  localparam logic [ENT_W-1:0] ENT_RESET = {1'b0, FMT_NONE, {XLEN{1'b0}}};

  logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      ins_s;
  logic [31:0]      imm32_s;
  logic [2:0]       fmt_s;
  logic             ill_s;
  logic [ENT_W-1:0] ent_s;

  assign ins_s   = bus.Instruction;
  assign full_s  = (occ_r == OCC_W'(FIFO_DEPTH));
  assign empty_s = (occ_r == {OCC_W{1'b0}});
  assign push_s  = bus.in_valid && !full_s;
  assign pop_s   = bus.out_ready && !empty_s;

  // Opcode decode to a 32-bit sign-extended immediate and its format code.
  always_comb begin
    imm32_s = 32'h0000_0000;
    fmt_s   = FMT_NONE;
    ill_s   = 1'b0;
    case (ins_s[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        imm32_s = {{20{ins_s[31]}}, ins_s[31:20]};
        fmt_s   = FMT_I;
      end
      7'b0100011: begin
        imm32_s = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
        fmt_s   = FMT_S;
      end
      7'b1100011: begin
        imm32_s = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
        fmt_s   = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm32_s = {ins_s[31:12], 12'h000};
        fmt_s   = FMT_U;
      end
      7'b1101111: begin
        imm32_s = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
        fmt_s   = FMT_J;
      end
      default: begin
        imm32_s = 32'h0000_0000;
        fmt_s   = FMT_NONE;
        ill_s   = 1'b1;
      end
    endcase
  end

  assign ent_s = {ill_s, fmt_s, XLEN'($signed(imm32_s))};

  // FIFO storage, pointers and occupancy; a simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= ENT_RESET;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= ent_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        occ_r <= occ_r + OCC_W'(1);
      end else if (pop_s && !push_s) begin
        occ_r <= occ_r - OCC_W'(1);
      end else begin
        occ_r <= occ_r;
      end
    end
  end

  assign bus.in_ready  = !full_s;
  assign bus.out_valid = !empty_s;
  assign {bus.illegal, bus.imm_fmt, bus.imm_data} = mem_r[rd_ptr_r];

`ifdef IMMGEN_STATS_EN
  // Saturating accept / illegal-opcode counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_cnt  <= {CNT_W{1'b0}};
      illegal_cnt <= {CNT_W{1'b0}};
    end else begin
      if (push_s && (accept_cnt != {CNT_W{1'b1}})) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (push_s && ill_s && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end
`endif
endmodule
